// File: rtl/imm_ext_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imm_ext_pkg
// Description : Shared ext_op encoding constants for the immediate extender.
// Revision    : 1.0 - initial release
// ============================================================================
package imm_ext_pkg;

  localparam int EXT_OP_W = 3;

  localparam logic [EXT_OP_W-1:0] EXT_ZERO   = 3'd0;
  localparam logic [EXT_OP_W-1:0] EXT_SIGN   = 3'd1;
  localparam logic [EXT_OP_W-1:0] EXT_HIGH   = 3'd2;
  localparam logic [EXT_OP_W-1:0] EXT_BRANCH = 3'd3;
  localparam logic [EXT_OP_W-1:0] EXT_BYTE   = 3'd4;

endpackage
`default_nettype wire

// File: rtl/imm_ext_core.sv
`default_nettype none
// ============================================================================
// Module      : imm_ext_core
// Description : Combinational immediate extender (imm, ext_op -> value, err).
//               BRANCH mode exists only when IMM_EXT_BRANCH_EN is defined;
//               otherwise ext_op 3 is reported as reserved.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]     imm,
  input  logic [EXT_OP_W-1:0] ext_op,
  output logic [OUT_W-1:0]    value,
  output logic                err
);

  logic [OUT_W-1:0] sext_w;

  assign sext_w = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};

  // Select the extension mode; reserved encodings yield zero with err set.
  always_comb begin
    value = '0;
    err   = 1'b0;
    case (ext_op)
      EXT_ZERO:   value = {{(OUT_W-IN_W){1'b0}}, imm};
      EXT_SIGN:   value = sext_w;
      EXT_HIGH:   value = {imm, {(OUT_W-IN_W){1'b0}}};
`ifdef IMM_EXT_BRANCH_EN
      EXT_BRANCH: value = sext_w << 2;
`endif
      EXT_BYTE:   value = {{(OUT_W-8){imm[7]}}, imm[7:0]};
      default: begin
        value = '0;
        err   = 1'b1;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/imm_ext_pipe.sv
`default_nettype none
// ============================================================================
// Module      : imm_ext_pipe
// Description : Immediate extender followed by a DEPTH-entry in-order buffer
//               with valid/ready handshakes, flush and synchronous reset.
//               Macro IMM_EXT_BRANCH_EN enables BRANCH mode (ext_op 3).
// Revision    : 1.0 - initial release
// ============================================================================
module imm_ext_pipe
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int DEPTH = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IN_W-1:0]     imm,
  input  logic [EXT_OP_W-1:0] ext_op,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUT_W-1:0]    out_data,
  output logic                out_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [OUT_W-1:0] ext_value_w;
  logic             ext_err_w;

  logic [OUT_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] err_q;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  logic push_w;
  logic pop_w;

  imm_ext_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .imm    (imm),
    .ext_op (ext_op),
    .value  (ext_value_w),
    .err    (ext_err_w)
  );

  // Handshake flags depend only on registered count, so out_ready never
  // reaches in_ready combinationally.
  assign in_ready  = (count_q < CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push_w    = in_valid && in_ready;
  assign pop_w     = out_valid && out_ready;

  // Gate the head entry so an empty buffer never exposes stale storage.
  assign out_data = out_valid ? data_q[rd_ptr_q] : '0;
  assign out_err  = out_valid ? err_q[rd_ptr_q]  : 1'b0;

  // Next-state for pointers and count; flush discards everything in flight.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_w) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_w)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_w, pop_w})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register; reset outranks flush and transfers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage needs no reset; a write under flush/reset is never exposed
  // because the write pointer and count do not advance.
  always_ff @(posedge clk) begin
    if (push_w) begin
      data_q[wr_ptr_q] <= ext_value_w;
      err_q[wr_ptr_q]  <= ext_err_w;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_imm_ext_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_imm_ext_pipe
// Description : Self-checking bench for imm_ext_pipe (default parameters).
//               Expectations for ext_op 3 follow IMM_EXT_BRANCH_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_ext_pipe;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic        in_ready, out_valid, out_err;
  logic [15:0] imm;
  logic [2:0]  ext_op;
  logic [31:0] out_data;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model queue entries: {err, data}
  logic [32:0] mq[$];

  imm_ext_pipe #(.IN_W(16), .OUT_W(32), .DEPTH(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .imm       (imm),
    .ext_op    (ext_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Extension rules expressed as plain integer arithmetic.
  function automatic logic [32:0] ext_model(input logic [15:0] v, input logic [2:0] op);
    int s, b;
    logic [31:0] r;
    s = v[15] ? int'(v) - 65536 : int'(v);
    b = int'(v[7:0]);
    if (b >= 128) b = b - 256;
    case (op)
      3'd0: begin r = 32'(int'(v));       return {1'b0, r}; end
      3'd1: begin r = s;                  return {1'b0, r}; end
      3'd2: begin r = 32'(int'(v) * 65536); return {1'b0, r}; end
`ifdef IMM_EXT_BRANCH_EN
      3'd3: begin r = s * 4;              return {1'b0, r}; end
`endif
      3'd4: begin r = b;                  return {1'b0, r}; end
      default: return {1'b1, 32'h0};
    endcase
  endfunction

  // Reference behaviour of the buffer, advanced on each rising edge.
  always @(posedge clk) begin
    bit do_pop, do_push;
    if (reset || flush) begin
      mq.delete();
    end else begin
      do_pop  = (mq.size() != 0) && out_ready;
      do_push = in_valid && (mq.size() < 2);
      if (do_pop)  void'(mq.pop_front());
      if (do_push) mq.push_back(ext_model(imm, ext_op));
    end
  end

  // Compare DUT against the model every cycle, away from the rising edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("mdl_out_valid", 33'(out_valid), 33'(mq.size() != 0));
      check("mdl_in_ready",  33'(in_ready),  33'(mq.size() < 2));
      check("mdl_head", {out_err, out_data}, (mq.size() != 0) ? mq[0] : 33'h0);
    end
  end

  task automatic single(input string name, input logic [15:0] v, input logic [2:0] op,
                        input logic [31:0] exp_d, input logic exp_e);
    in_valid = 1'b1; imm = v; ext_op = op;
    @(negedge clk);
    in_valid = 1'b0;
    check({name, "_valid"}, 33'(out_valid), 33'h1);
    check({name, "_data"},  33'(out_data),  33'(exp_d));
    check({name, "_err"},   33'(out_err),   33'(exp_e));
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    imm = '0; ext_op = '0;
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_in_ready",  33'(in_ready),  33'h1);
    check("rst_out_valid", 33'(out_valid), 33'h0);
    check("rst_out_data",  33'(out_data),  33'h0);
    check("rst_out_err",   33'(out_err),   33'h0);
    reset = 1'b0;

    // Literal pins of the model itself
    check("mdl_pin_sign", ext_model(16'h8001, 3'd1), {1'b0, 32'hFFFF8001});
    check("mdl_pin_high", ext_model(16'h80F0, 3'd2), {1'b0, 32'h80F00000});

    // Basic sign push, then empty
    single("sign", 16'h8001, 3'd1, 32'hFFFF8001, 1'b0);
    check("sign_empty_after", 33'(out_valid), 33'h0);

    single("zero", 16'h80F0, 3'd0, 32'h000080F0, 1'b0);
    single("high", 16'h80F0, 3'd2, 32'h80F00000, 1'b0);
    single("byte", 16'h80F0, 3'd4, 32'hFFFFFFF0, 1'b0);
    single("rsv6", 16'h1234, 3'd6, 32'h0, 1'b1);
`ifdef IMM_EXT_BRANCH_EN
    single("branch", 16'hFFFF, 3'd3, 32'hFFFFFFFC, 1'b0);
`else
    single("branch_off", 16'hFFFF, 3'd3, 32'h0, 1'b1);
`endif

    // Back-pressure: A,B fill buffer, C held by producer until space
    out_ready = 1'b0;
    in_valid = 1'b1; imm = 16'h00AA; ext_op = 3'd0;
    @(negedge clk);
    imm = 16'h00BB;
    @(negedge clk);
    imm = 16'h00CC;
    @(negedge clk);
    check("bp_full_ready", 33'(in_ready), 33'h0);
    check("bp_hold_A", 33'(out_data), 33'h000000AA);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_head_B", 33'(out_data), 33'h000000BB);
    check("bp_ready_again", 33'(in_ready), 33'h1);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_head_C", 33'(out_data), 33'h000000CC);
    @(negedge clk);
    check("bp_drained", 33'(out_valid), 33'h0);

    // Flush with simultaneous push
    out_ready = 1'b0;
    in_valid = 1'b1; imm = 16'h0011; ext_op = 3'd0;
    @(negedge clk);
    imm = 16'h0022;
    @(negedge clk);
    check("fl_two_held", 33'(out_valid), 33'h1);
    flush = 1'b1; imm = 16'h5555;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    check("fl_out_valid", 33'(out_valid), 33'h0);
    check("fl_in_ready",  33'(in_ready),  33'h1);
    @(negedge clk);
    check("fl_push_absent", 33'(out_valid), 33'h0);

    // Reset with one entry buffered and a push pending
    in_valid = 1'b1; imm = 16'h0033; ext_op = 3'd1;
    @(negedge clk);
    reset = 1'b1; imm = 16'h0044;
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0;
    check("rs_out_valid", 33'(out_valid), 33'h0);
    check("rs_out_data",  33'(out_data),  33'h0);
    check("rs_in_ready",  33'(in_ready),  33'h1);

    // Mixed traffic exercising pointer wrap and simultaneous push/pop
    for (int i = 0; i < 80; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      imm       = 16'($urandom);
      ext_op    = 3'($urandom_range(0, 7));
      flush     = ($urandom_range(0, 39) == 0);
      @(negedge clk);
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("final_drained", 33'(out_valid), 33'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/imm_ext_pipe.md
IMM_EXT_PIPE -- requirements
Module: imm_ext_pipe

Interface
REQ-001 SHALL provide parameter IN_W, default 16, immediate input width.
REQ-002 SHALL provide parameter OUT_W, default 32, extended output width; OUT_W > IN_W, IN_W >= 8.
REQ-003 SHALL provide parameter DEPTH, default 2, buffer entries, power of two, >= 2.
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port flush  input  1  discard all buffered entries.
REQ-007 SHALL have port in_valid  input  1  producer offers imm/ext_op.
REQ-008 SHALL have port in_ready  output  1  block can accept this cycle.
REQ-009 SHALL have port imm  input  IN_W  raw immediate field.
REQ-010 SHALL have port ext_op  input  3  extension mode select.
REQ-011 SHALL have port out_valid  output  1  head entry present.
REQ-012 SHALL have port out_ready  input  1  consumer takes head this cycle.
REQ-013 SHALL have port out_data  output  OUT_W  extended value of head entry.
REQ-014 SHALL have port out_err  output  1  head entry had a reserved/disabled ext_op.

Function
REQ-015 SHALL encode ext_op: 0 ZERO (zero-extend), 1 SIGN (sign-extend), 2 HIGH (imm placed in top IN_W bits, low bits zero), 3 BRANCH (sign-extend then shift left 2, bits above OUT_W dropped), 4 BYTE (sign-extend imm[7:0]); 5-7 reserved.
REQ-016 SHALL compute the extension combinationally at input and store result plus err bit per entry.
REQ-017 SHALL, for reserved ext_op, store out_data = 0 and out_err = 1; otherwise out_err = 0.
REQ-018 SHALL accept an entry on a rising edge where in_valid && in_ready.
REQ-019 SHALL pop the head on a rising edge where out_valid && out_ready.
REQ-020 SHALL drive in_ready = (count < DEPTH), independent of out_ready in the same cycle (no combinational path out_ready->in_ready).
REQ-021 SHALL have latency 1: entry accepted at edge N into empty buffer is valid on out_* after edge N.
REQ-022 SHALL deliver entries strictly in acceptance order; read/write pointers wrap modulo DEPTH.
REQ-023 SHALL, on simultaneous push and pop with 0 < count < DEPTH, keep count unchanged.
REQ-024 SHALL hold out_data/out_err stable while out_valid && !out_ready.
REQ-025 SHALL, when flush is high at an edge, set count and both pointers to 0, discarding any simultaneous push and pop; flush has priority over all transfers.
REQ-026 SHALL drive out_valid = (count != 0) and out_data/out_err = 0 when count == 0.

Reset
REQ-027 SHALL, when reset is high at an edge, clear count, read and write pointers; reset has priority over flush and transfers.
REQ-028 SHALL give reset values out_valid = 0, out_data = 0, out_err = 0, in_ready = 1.
REQ-029 SHALL not require entry storage to be reset; output gating per REQ-026 hides stale contents.
REQ-030 SHALL discard any partial transfer in progress when reset asserts mid-operation.

Configuration
REQ-031 SHALL compile BRANCH mode only when macro IMM_EXT_BRANCH_EN is defined.
REQ-032 SHALL, with IMM_EXT_BRANCH_EN defined, implement ext_op 3 per REQ-015.
REQ-033 SHALL, without IMM_EXT_BRANCH_EN, treat ext_op 3 as reserved (out_data 0, out_err 1).

Structure
REQ-034 SHALL place ext_op encoding constants (EXT_ZERO, EXT_SIGN, EXT_HIGH, EXT_BRANCH, EXT_BYTE) and the op width (3) in shared package imm_ext_pkg.
REQ-035 SHALL isolate the combinational extender in sub-module imm_ext_core (imm, ext_op -> value, err), parametrised by IN_W/OUT_W.
REQ-036 SHALL keep buffer, pointers and count in imm_ext_pipe itself.

Verification
REQ-037 SHALL cover: reset, push imm=16'h8001 op SIGN, out_ready=1 -> next cycle out_valid=1, out_data=32'hFFFF8001, out_err=0; following cycle out_valid=0.
REQ-038 SHALL cover: ops ZERO/HIGH/BYTE on imm=16'h80F0 -> 32'h000080F0 / 32'h80F00000 / 32'hFFFFFFF0.
REQ-039 SHALL cover: out_ready=0, push 3 entries -> in_ready=0 after 2 accepted, third held by producer; release out_ready -> outputs A,B,C in order with no loss or duplication.
REQ-040 SHALL cover: ext_op=6 imm=16'h1234 -> out_data=0, out_err=1; ext_op=3 imm=16'hFFFF -> 32'hFFFFFFFC with IMM_EXT_BRANCH_EN, 0 with out_err=1 without.
REQ-041 SHALL cover: buffer holding 2 entries, flush and in_valid high same edge -> next cycle out_valid=0, in_ready=1, pushed entry absent.
REQ-042 SHALL cover: reset asserted with 1 entry buffered and push pending -> next cycle out_valid=0, out_data=0, in_ready=1.
